lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Parametrised load/store unit front end between the CPU memory stage and a synchronous-read data RAM.
//  Accepts one request at a time over a valid/ready handshake and drives a byte-enabled RAM port.
//  Sign/zero-extends LB/LBU/LH/LHU; traps misaligned or illegal-size accesses.
//  Returns read data or a write acknowledge over a valid/ready response channel.
// PARAMETERS
//  MEM_AW     10  RAM word-address width; depth = 2**MEM_AW words (byte addr bits [MEM_AW+1:2])
//  RD_LAT     1   RAM read latency in cycles, legal 1..4
//  MISAL_TRAP 1   1: misaligned access -> error response, no RAM access; 0: low addr bits forced to alignment
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  req_valid    in   1       request valid
//  req_ready    out  1       request accepted when req_valid & req_ready
//  req_addr     in   32      byte address; bits above MEM_AW+1 ignored (aliasing)
//  req_wdata    in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  req_size     in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1       1: zero-extend loads (LBU/LHU); ignored for word and stores
//  req_we       in   1       1 store, 0 load
//  rsp_valid    out  1       response valid, held until rsp_ready
//  rsp_ready    in   1       response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  32      extended load data; 0 for stores and errors
//  rsp_err      out  1       misaligned or illegal-size request
//  mem_en       out  1       RAM port enable
//  mem_we       out  4       RAM byte write enables, bit i = byte lane i
//  mem_addr     out  MEM_AW  RAM word address
//  mem_wdata    out  32      lane-shifted store data, unused lanes 0
//  mem_rdata    in   32      RAM read data, valid RD_LAT cycles after mem_en cycle
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1 after reset released (0 while rst high); rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wait counter=0.
//  FSM: IDLE -> (accept, legal) ACCESS; IDLE -> (accept, error) RESP with rsp_err=1, no RAM activity.
//   ACCESS: one cycle, mem_en=1, mem_addr/mem_wdata/mem_we from registered request.
//   store: ACCESS -> RESP. load: ACCESS -> WAIT; WAIT counts RD_LAT cycles, captures mem_rdata on last.
//   RESP: rsp_valid=1; on rsp_ready -> IDLE. req_ready=1 only in IDLE (no request overlap).
//  Latency (accept edge = cycle T): error rsp_valid in T+1; store rsp_valid in T+2; load in T+2+RD_LAT.
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0. size 11 always error regardless of MISAL_TRAP.
//  Byte enables: byte 0001<<off; half 0011<<{off[1],1'b0}; word 1111; loads 0000. off=addr[1:0].
//  Write data: byte wdata[7:0]<<8*off; half wdata[15:0]<<16*off[1]; word as-is.
//  Load extract: select lane by off; sign-extend bit 7/15 unless req_unsigned; word passed through.
//  rsp_rdata/rsp_err stable while rsp_valid high and rsp_ready low.
//  Reset mid-operation: rst forces mem_en=0 and mem_we=0 in the same cycle (no partial store);
//   in-flight load discarded, FSM -> IDLE, rsp_valid dropped, no response emitted.
//  mem_en/mem_we are 0 in all states other than ACCESS.
// TESTING
//  SW 0x100 data 0xDEADBEEF, then LW 0x100 -> mem_we=1111 in T+1; load rsp_rdata=0xDEADBEEF in T+2+RD_LAT.
//  SB 0x0000_0103 data 0x000000A5, then LB 0x103 -> mem_we=1000, mem_wdata=0xA5000000; LB=0xFFFFFFA5, LBU=0x000000A5.
//  SH 0x202 data 0x8001, then LH 0x202 -> mem_we=1100; LH=0xFFFF8001, LHU=0x00008001; other lanes unchanged.
//  LW 0x101 with MISAL_TRAP=1 -> rsp_err=1, rsp_valid in T+1, mem_en never asserted; req_size=11 -> same.
//  Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; accept next after handshake.
//  Assert rst during ACCESS of SW 0x300 -> mem_we=0000, RAM word 0x300 unchanged, rsp_valid=0, req_ready=1 next cycle.
//  Repeat load tests for RD_LAT=1 and RD_LAT=3; MEM_AW=10 address 0x1100 aliases to 0x100.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store front end between CPU memory stage and a synchronous-read data RAM
module lsu_mem_ctrl #(
    parameter int MEM_AW     = 10,
    parameter int RD_LAT     = 1,
    parameter int MISAL_TRAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic              req_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              we_q, we_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]  off_al;
    logic        misal;
    logic        req_err;
    logic [3:0]  be_in;
    logic [31:0] wd_in;
    logic [31:0] rd_b_sh;
    logic [31:0] rd_h_sh;
    logic [31:0] load_ext;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

    // Request decode: alignment check, lane enables and lane-shifted store data
    always_comb begin
        misal   = ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err = (req_size == 2'b11) || ((MISAL_TRAP != 0) && misal);
        off_al  = req_addr[1:0];
        be_in   = 4'b0000;
        wd_in   = 32'h0;
        case (req_size)
            2'b00: begin
                be_in = 4'b0001 << off_al;
                wd_in = {24'h0, req_wdata[7:0]} << {off_al, 3'b000};
            end
            2'b01: begin
                off_al = {req_addr[1], 1'b0};
                be_in  = 4'b0011 << {off_al[1], 1'b0};
                wd_in  = {16'h0, req_wdata[15:0]} << {off_al[1], 4'b0000};
            end
            2'b10: begin
                off_al = 2'b00;
                be_in  = 4'b1111;
                wd_in  = req_wdata;
            end
            default: begin
                be_in = 4'b0000;
                wd_in = 32'h0;
            end
        endcase
    end

    always_comb begin
        rd_b_sh  = mem_rdata >> {off_q, 3'b000};
        rd_h_sh  = mem_rdata >> {off_q[1], 4'b0000};
        load_ext = mem_rdata;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, rd_b_sh[7:0]} : {{24{rd_b_sh[7]}}, rd_b_sh[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, rd_h_sh[15:0]} : {{16{rd_h_sh[15]}}, rd_h_sh[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[MEM_AW+1:2];
                    off_d   = off_al;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    we_d    = req_we;
                    be_d    = req_we ? be_in : 4'b0000;
                    wdata_d = req_we ? wd_in : 32'h0;
                    rdata_d = 32'h0;
                    err_d   = req_err;
                    cnt_d   = 2'd0;
                    state_d = req_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d   = 2'd0;
                state_d = we_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                // mem_rdata is valid in the last of the RD_LAT wait cycles
                if (cnt_q == LAST_CNT) begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
            we_q    <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // rst gates the RAM strobes combinationally so a store caught mid-access never lands
    assign mem_en    = (state_q == S_ACCESS) && !rst;
    assign mem_we    = (mem_en && we_q) ? be_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed bench for lsu_mem_ctrl with RD_LAT=1 and RD_LAT=3 instances
module tb_lsu_mem_ctrl;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_we;
    logic        rsp_ready;

    logic        req_ready_1, rsp_valid_1, rsp_err_1, mem_en_1;
    logic [31:0] rsp_rdata_1, mem_wdata_1, mem_rdata_1;
    logic [3:0]  mem_we_1;
    logic [9:0]  mem_addr_1;
    logic        req_ready_3, rsp_valid_3, rsp_err_3, mem_en_3;
    logic [31:0] rsp_rdata_3, mem_wdata_3, mem_rdata_3;
    logic [3:0]  mem_we_3;
    logic [9:0]  mem_addr_3;

    int checks = 0;
    int errors = 0;

    int          lat1, lat3;
    logic [31:0] rd1, rd3;
    logic        er1, er3;
    logic        saw_en;
    logic [3:0]  we_c1;
    logic [31:0] wd_c1;
    logic [9:0]  ad_c1;

    lsu_mem_ctrl #(.MEM_AW(10), .RD_LAT(1), .MISAL_TRAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_1),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_we(req_we), .rsp_valid(rsp_valid_1),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
    );

    lsu_mem_ctrl #(.MEM_AW(10), .RD_LAT(3), .MISAL_TRAP(1)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_we(req_we), .rsp_valid(rsp_valid_3),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3)
    );

    // RAM models: registered read, further pipeline stages give the read latency
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] pipe1 [0:3];
    logic [31:0] pipe3 [0:3];

    always @(posedge clk) begin
        if (mem_en_1) begin
            for (int i = 0; i < 4; i++)
                if (mem_we_1[i]) mem1[mem_addr_1][8*i +: 8] <= mem_wdata_1[8*i +: 8];
            pipe1[0] <= mem1[mem_addr_1];
        end
        for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
    end

    always @(posedge clk) begin
        if (mem_en_3) begin
            for (int j = 0; j < 4; j++)
                if (mem_we_3[j]) mem3[mem_addr_3][8*j +: 8] <= mem_wdata_3[8*j +: 8];
            pipe3[0] <= mem3[mem_addr_3];
        end
        for (int j = 1; j < 4; j++) pipe3[j] <= pipe3[j-1];
    end

    assign mem_rdata_1 = pipe1[0];
    assign mem_rdata_3 = pipe3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bit d1, d3;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        d1 = 0; d3 = 0; saw_en = 1'b0; lat1 = -1; lat3 = -1;
        we_c1 = mem_we_1; wd_c1 = mem_wdata_1; ad_c1 = mem_addr_1;
        for (int c = 1; c <= 20 && !(d1 && d3); c++) begin
            if (c > 1) @(negedge clk);
            if (mem_en_1 || mem_en_3) saw_en = 1'b1;
            if (!d1 && rsp_valid_1) begin d1 = 1; lat1 = c; rd1 = rsp_rdata_1; er1 = rsp_err_1; end
            if (!d3 && rsp_valid_3) begin d3 = 1; lat3 = c; rd3 = rsp_rdata_3; er3 = rsp_err_3; end
        end
        checks++;
        if (!(d1 && d3)) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h got d1=%0d d3=%0d exp 1 1", addr, d1, d3);
        end
    endtask

    task automatic chk_load(input string name, input logic [31:0] exp);
        checks++;
        if (rd1 !== exp || rd3 !== exp || er1 !== 1'b0 || er3 !== 1'b0) begin
            errors++;
            $display("FAIL %s got %h/%h err %b/%b exp %h err 0", name, rd1, rd3, er1, er3, exp);
        end
        checks++;
        if (lat1 !== 3 || lat3 !== 5) begin
            errors++;
            $display("FAIL %s_lat got %0d/%0d exp 3/5", name, lat1, lat3);
        end
    endtask

    task automatic chk_store(input string name, input logic [3:0] exp_we, input logic [31:0] exp_wd,
                             input logic [9:0] exp_ad);
        checks++;
        if (we_c1 !== exp_we || wd_c1 !== exp_wd || ad_c1 !== exp_ad) begin
            errors++;
            $display("FAIL %s_port got we=%b wd=%h ad=%h exp we=%b wd=%h ad=%h",
                     name, we_c1, wd_c1, ad_c1, exp_we, exp_wd, exp_ad);
        end
        checks++;
        if (lat1 !== 2 || lat3 !== 2 || rd1 !== 32'h0 || er1 !== 1'b0 || er3 !== 1'b0) begin
            errors++;
            $display("FAIL %s_rsp got lat=%0d/%0d rdata=%h err=%b/%b exp lat=2/2 rdata=0 err=0",
                     name, lat1, lat3, rd1, er1, er3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready_1 !== 1'b0 || rsp_valid_1 !== 1'b0 || rsp_rdata_1 !== 32'h0 || rsp_err_1 !== 1'b0 ||
            mem_en_1 !== 1'b0 || mem_we_1 !== 4'b0 || mem_addr_1 !== 10'h0 || mem_wdata_1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b rd=%h e=%b en=%b we=%b a=%h wd=%h exp all 0",
                     req_ready_1, rsp_valid_1, rsp_rdata_1, rsp_err_1, mem_en_1, mem_we_1, mem_addr_1, mem_wdata_1);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready_1 !== 1'b1 || req_ready_3 !== 1'b1 || rsp_valid_3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b/%b v3=%b exp 1/1 0", req_ready_1, req_ready_3, rsp_valid_3);
        end
    endtask

    task automatic test_word();
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        chk_store("sw_100", 4'b1111, 32'hDEAD_BEEF, 10'h040);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        chk_load("lw_100", 32'hDEAD_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_1100, 32'h0);
        chk_load("lw_alias_1100", 32'hDEAD_BEEF);
    endtask

    task automatic test_byte();
        run_req(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5);
        chk_store("sb_103", 4'b1000, 32'hA500_0000, 10'h040);
        run_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        chk_load("lb_103", 32'hFFFF_FFA5);
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        chk_load("lbu_103", 32'h0000_00A5);
        run_req(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0);
        chk_load("lb_101", 32'hFFFF_FFBE);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        chk_load("lw_after_sb", 32'hA5AD_BEEF);
    endtask

    task automatic test_half();
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1122_3344);
        chk_store("sw_200", 4'b1111, 32'h1122_3344, 10'h080);
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_8001);
        chk_store("sh_202", 4'b1100, 32'h8001_0000, 10'h080);
        run_req(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0);
        chk_load("lh_202", 32'hFFFF_8001);
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0);
        chk_load("lhu_202", 32'h0000_8001);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
        chk_load("lw_after_sh", 32'h8001_3344);
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [0:2];
        logic [1:0]  sizes [0:2];
        addrs[0] = 32'h0000_0101; sizes[0] = 2'b10;
        addrs[1] = 32'h0000_0100; sizes[1] = 2'b11;
        addrs[2] = 32'h0000_0203; sizes[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            run_req(1'b0, sizes[k], 1'b0, addrs[k], 32'h0);
            checks++;
            if (er1 !== 1'b1 || er3 !== 1'b1 || lat1 !== 1 || lat3 !== 1 || saw_en !== 1'b0 ||
                rd1 !== 32'h0 || rd3 !== 32'h0) begin
                errors++;
                $display("FAIL err_case%0d got err=%b/%b lat=%0d/%0d en=%b rd=%h/%h exp err=1 lat=1 en=0 rd=0",
                         k, er1, er3, lat1, lat3, saw_en, rd1, rd3);
            end
        end
        run_req(1'b1, 2'b11, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF);
        checks++;
        if (er1 !== 1'b1 || lat1 !== 1 || saw_en !== 1'b0) begin
            errors++;
            $display("FAIL err_store_size3 got err=%b lat=%0d en=%b exp 1 1 0", er1, lat1, saw_en);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
        chk_load("lw_after_err", 32'h8001_3344);
    endtask

    task automatic test_hold();
        int n;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_0100;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h0000_0180; req_wdata = 32'h0000_0055;
        n = 0;
        while (!(rsp_valid_1 && rsp_valid_3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid_1 !== 1'b1 || rsp_valid_3 !== 1'b1 || rsp_rdata_1 !== 32'hA5AD_BEEF ||
                rsp_rdata_3 !== 32'hA5AD_BEEF || req_ready_1 !== 1'b0 || req_ready_3 !== 1'b0) begin
                errors++;
                $display("FAIL hold_cyc%0d got v=%b/%b rd=%h/%h rdy=%b/%b exp v=1 rd=a5adbeef rdy=0",
                         k, rsp_valid_1, rsp_valid_3, rsp_rdata_1, rsp_rdata_3, req_ready_1, req_ready_3);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready_1 !== 1'b1 || req_ready_3 !== 1'b1 || rsp_valid_1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got rdy=%b/%b v=%b exp 1/1 0", req_ready_1, req_ready_3, rsp_valid_1);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(rsp_valid_1 && rsp_valid_3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0180, 32'h0);
        chk_load("lw_after_hold", 32'h0000_0055);
    endtask

    task automatic test_reset_mid();
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h1234_5678);
        chk_store("sw_300", 4'b1111, 32'h1234_5678, 10'h0C0);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0300; req_wdata = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_en_1 !== 1'b0 || mem_we_1 !== 4'b0000 || mem_en_3 !== 1'b0 || mem_we_3 !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_strobe got en=%b/%b we=%b/%b exp 0 0000", mem_en_1, mem_en_3, mem_we_1, mem_we_3);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready_1 !== 1'b1 || req_ready_3 !== 1'b1 || rsp_valid_1 !== 1'b0 || rsp_valid_3 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state got rdy=%b/%b v=%b/%b exp 1 0", req_ready_1, req_ready_3, rsp_valid_1, rsp_valid_3);
        end
        checks++;
        if (mem1[10'h0C0] !== 32'h1234_5678 || mem3[10'h0C0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rst_mid_ram got %h/%h exp 12345678", mem1[10'h0C0], mem3[10'h0C0]);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        chk_load("lw_after_rst", 32'h1234_5678);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'b00; req_unsigned = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
